// File: rtl/psram_rd_capture_pkg.sv
// Shared state encodings and helpers for the PSRAM read-data capture stage.
package psram_rd_capture_pkg;

  typedef enum logic [1:0] {
    PSRAM_RDCAP_IDLE = 2'd0,
    PSRAM_RDCAP_WAIT = 2'd1,
    PSRAM_RDCAP_CAPT = 2'd2,
    PSRAM_RDCAP_DONE = 2'd3
  } rdcap_state_e;

  localparam int PSRAM_RDCAP_MAXLEN = 8;

  // A zero length still returns one byte; lengths past the word size are clipped.
  function automatic logic [3:0] rdcap_norm_len(input logic [3:0] len,
                                                input logic [3:0] max_len);
    if (len == 4'd0)
      return 4'd1;
    else if (len > max_len)
      return max_len;
    else
      return len;
  endfunction

endpackage

// File: rtl/psram_dqs_sync.sv
// DQS synchronizer with a matching IO delay pipe, so each detected DQS edge
// lines up with the DQ byte that was on the pads when DQS toggled.
module psram_dqs_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       dqs_raw_i,
  input  logic [7:0] io_raw_i,
  output logic       dqs_edge_o,
  output logic [7:0] io_d_o
);

  logic [SYNC_STAGES-1:0]      dqs_sync;
  logic [SYNC_STAGES-1:0][7:0] io_pipe;
  logic                        dqs_q;

  // NOTE: the IO pipe is a shift register, not a memory, so every stage is
  // reset; otherwise stale pad data could be captured after reset release.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      dqs_sync <= '0;
      io_pipe  <= '0;
      dqs_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make every stage shift by exactly one
      // flop per clock regardless of statement order.
      dqs_sync <= {dqs_sync[SYNC_STAGES-2:0], dqs_raw_i};
      io_pipe  <= {io_pipe[SYNC_STAGES-2:0], io_raw_i};
      dqs_q    <= dqs_sync[SYNC_STAGES-1];
    end
  end

  // Both DQS polarities mark a byte (DDR).
  assign dqs_edge_o = dqs_sync[SYNC_STAGES-1] ^ dqs_q;
  assign io_d_o     = io_pipe[SYNC_STAGES-1];

endmodule

// File: rtl/psram_rd_capture.sv
// PSRAM RDATA capture: counts DQS edges, shifts DQ bytes into a word and
// returns it with a valid pulse, or gives up via timeout/abort.
module psram_rd_capture
  import psram_rd_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DATA_WIDTH  = 64,
  parameter int TMO_WIDTH   = 8
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_start_i,
  input  logic [3:0]            rd_len_i,
  input  logic [TMO_WIDTH-1:0]  rd_tmo_i,
  input  logic                  rd_abort_i,
  input  logic                  psram_dqs_in_i,
  input  logic [7:0]            psram_io_in_i,
  output logic                  rd_busy_o,
  output logic                  rd_valid_o,
  output logic [DATA_WIDTH-1:0] rd_data_o,
  output logic [7:0]            rd_byte_o,
  output logic                  rd_timeout_o
);

  localparam logic [3:0] MAX_LEN = 4'(DATA_WIDTH / 8);

  rdcap_state_e         state;
  logic [3:0]           byte_cnt;
  logic [3:0]           len_q;
  logic [TMO_WIDTH-1:0] tmo_cnt;
  logic                 dqs_edge;
  logic [7:0]           io_d;
  logic [3:0]           next_cnt;

  psram_dqs_sync #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_dqs_sync (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .dqs_raw_i  (psram_dqs_in_i),
    .io_raw_i   (psram_io_in_i),
    .dqs_edge_o (dqs_edge),
    .io_d_o     (io_d)
  );

  assign next_cnt = byte_cnt + 4'd1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= PSRAM_RDCAP_IDLE;
      byte_cnt     <= '0;
      len_q        <= '0;
      tmo_cnt      <= '0;
      rd_data_o    <= '0;
      rd_busy_o    <= 1'b0;
      rd_valid_o   <= 1'b0;
      rd_timeout_o <= 1'b0;
    end else begin
      rd_valid_o   <= 1'b0;
      rd_timeout_o <= 1'b0;
      if (rd_abort_i) begin
        // Abort outranks start, edge and timeout in the same cycle.
        state     <= PSRAM_RDCAP_IDLE;
        rd_busy_o <= 1'b0;
      end else begin
        case (state)
          PSRAM_RDCAP_IDLE: begin
            if (rd_start_i) begin
              state     <= PSRAM_RDCAP_WAIT;
              rd_busy_o <= 1'b1;
              rd_data_o <= '0;
              byte_cnt  <= '0;
              tmo_cnt   <= rd_tmo_i;
              len_q     <= rdcap_norm_len(rd_len_i, MAX_LEN);
            end
          end
          PSRAM_RDCAP_WAIT, PSRAM_RDCAP_CAPT: begin
            if (dqs_edge) begin
              rd_data_o <= {rd_data_o[DATA_WIDTH-9:0], io_d};
              byte_cnt  <= next_cnt;
              tmo_cnt   <= rd_tmo_i;
              if (next_cnt == len_q) begin
                state      <= PSRAM_RDCAP_DONE;
                rd_valid_o <= 1'b1;
              end else begin
                state <= PSRAM_RDCAP_CAPT;
              end
            end else if (tmo_cnt == '0) begin
              // Partial data stays in rd_data_o for debug.
              state        <= PSRAM_RDCAP_IDLE;
              rd_busy_o    <= 1'b0;
              rd_timeout_o <= 1'b1;
            end else begin
              tmo_cnt <= tmo_cnt - TMO_WIDTH'(1);
            end
          end
          PSRAM_RDCAP_DONE: begin
            state     <= PSRAM_RDCAP_IDLE;
            rd_busy_o <= 1'b0;
          end
          default: begin
            state     <= PSRAM_RDCAP_IDLE;
            rd_busy_o <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rd_byte_o = rd_data_o[7:0];

endmodule
